// File: rtl/branch_redirect_ctrl.sv
// Control-flow resolution: taken decode, PC redirect handshake, post-redirect flush window
// and branch/taken statistics.
module branch_redirect_ctrl #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CWIDTH       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid_i,
  output logic              br_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic [DWIDTH-1:0] target_i,
  output logic              redirect_valid_o,
  input  logic              redirect_ready_i,
  output logic [DWIDTH-1:0] redirect_pc_o,
  output logic              flush_o,
  output logic              misalign_o,
  output logic              illegal_o,
  input  logic              clear_cnt_i,
  output logic [CWIDTH-1:0] branch_count_o,
  output logic [CWIDTH-1:0] taken_count_o
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [FW-1:0]     flush_cnt;
  logic              is_branch, is_jal, is_jalr, counted;
  logic              taken, illegal_dec;
  logic [DWIDTH-1:0] target_eff;
  logic              accept, go_redirect, go_misalign, redirect_done;

  always_comb begin
    is_branch   = (opcode_i == 7'b1100011);
    is_jal      = (opcode_i == 7'b1101111);
    is_jalr     = (opcode_i == 7'b1100111);
    counted     = is_branch | is_jal | is_jalr;
    taken       = 1'b0;
    illegal_dec = 1'b0;
    if (is_branch) begin
      case (funct3_i)
        3'b000:         taken = breq_i;
        3'b001:         taken = !breq_i;
        3'b100, 3'b110: taken = brlt_i;
        3'b101, 3'b111: taken = !brlt_i;
        default:        illegal_dec = 1'b1;
      endcase
    end else if (is_jal || is_jalr) begin
      taken = 1'b1;
    end
    target_eff = is_jalr ? {target_i[DWIDTH-1:1], 1'b0} : target_i;
  end

  assign accept        = br_valid_i && (state == IDLE);
  assign go_redirect   = accept && taken && !target_eff[1];
  assign go_misalign   = accept && taken && target_eff[1];
  assign redirect_done = (state == REDIRECT) && redirect_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (go_redirect) state_nxt = REDIRECT;
      REDIRECT: if (redirect_done) state_nxt = FLUSH;
      FLUSH:    if (flush_cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Down-counter covers FLUSH_CYCLES cycles in FLUSH: loaded with N-1, leaves at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (redirect_done) begin
      flush_cnt <= FW'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_o <= '0;
      misalign_o    <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      if (go_redirect) redirect_pc_o <= target_eff;
      misalign_o <= go_misalign;
      illegal_o  <= accept && illegal_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_o <= '0;
      taken_count_o  <= '0;
    end else if (clear_cnt_i) begin
      branch_count_o <= '0;
      taken_count_o  <= '0;
    end else if (accept) begin
      if (counted) branch_count_o <= branch_count_o + 1'b1;
      if (taken)   taken_count_o  <= taken_count_o + 1'b1;
    end
  end

  assign br_ready_o       = (state == IDLE);
  assign redirect_valid_o = (state == REDIRECT);
  assign flush_o          = (state != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations (CWIDTH=4).
module tb_branch_redirect_ctrl;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk, rst_n;
  logic        br_valid_i, br_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        breq_i, brlt_i;
  logic [31:0] target_i;
  logic        redirect_valid_o, redirect_ready_i;
  logic [31:0] redirect_pc_o;
  logic        flush_o, misalign_o, illegal_o, clear_cnt_i;
  logic [3:0]  branch_count_o, taken_count_o;

  int n_checks = 0;
  int n_pass   = 0;
  int bc = 0;
  int tc = 0;
  int fl, rv;

  branch_redirect_ctrl #(.DWIDTH(32), .FLUSH_CYCLES(2), .CWIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i),
    .breq_i(breq_i), .brlt_i(brlt_i), .target_i(target_i),
    .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .misalign_o(misalign_o), .illegal_o(illegal_o),
    .clear_cnt_i(clear_cnt_i),
    .branch_count_o(branch_count_o), .taken_count_o(taken_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                     input logic lt, input logic [31:0] tgt);
    br_valid_i = 1'b1;
    opcode_i   = op;
    funct3_i   = f3;
    breq_i     = eq;
    brlt_i     = lt;
    target_i   = tgt;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_bc"}, 32'(branch_count_o), 32'(bc % 16));
    chk({tag, "_tc"}, 32'(taken_count_o), 32'(tc % 16));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(br_ready_o), 32'd1);
    chk({tag, "_rv"}, 32'(redirect_valid_o), 32'd0);
    chk({tag, "_fl"}, 32'(flush_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; br_valid_i = 1'b0; opcode_i = '0; funct3_i = '0;
    breq_i = 1'b0; brlt_i = 1'b0; target_i = '0;
    redirect_ready_i = 1'b1; clear_cnt_i = 1'b0;

    // reset state
    #12;
    chk_idle("rst");
    chk("rst_pc", redirect_pc_o, 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_ill", 32'(illegal_o), 32'd0);
    chk_counts("rst");
    rst_n = 1'b1;
    cyc();

    // 1: BEQ taken, fetch ready
    req(OP_BR, 3'b000, 1'b1, 1'b0, 32'h100);
    cyc(); br_valid_i = 1'b0; bc++; tc++;
    chk("t1_rv", 32'(redirect_valid_o), 32'd1);
    chk("t1_pc", redirect_pc_o, 32'h100);
    chk("t1_fl0", 32'(flush_o), 32'd1);
    chk("t1_rdy", 32'(br_ready_o), 32'd0);
    chk_counts("t1");
    cyc();
    chk("t1_rv1", 32'(redirect_valid_o), 32'd0);
    chk("t1_fl1", 32'(flush_o), 32'd1);
    cyc();
    chk("t1_fl2", 32'(flush_o), 32'd1);
    cyc();
    chk_idle("t1_end");

    // 2: BNE not taken, back-to-back
    req(OP_BR, 3'b001, 1'b1, 1'b0, 32'h180);
    for (int i = 0; i < 3; i++) begin
      cyc(); bc++;
      chk_idle("t2");
      chk_counts("t2");
    end
    br_valid_i = 1'b0;

    // 3: JALR misaligned-by-one target, fetch stalls 4 cycles
    req(OP_JALR, 3'b000, 1'b0, 1'b0, 32'h205);
    cyc(); br_valid_i = 1'b0; bc++; tc++;
    chk_counts("t3");
    fl = 0; rv = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_ready_i = (i >= 4);
      if (!flush_o) break;
      fl++;
      if (redirect_valid_o) begin
        rv++;
        chk("t3_pc", redirect_pc_o, 32'h204);
      end
      cyc();
    end
    chk("t3_rvcyc", 32'(rv), 32'd5);
    chk("t3_flcyc", 32'(fl), 32'd7);
    chk_idle("t3_end");
    redirect_ready_i = 1'b1;

    // 4: misaligned JAL, illegal funct3, non-control opcode
    req(OP_JAL, 3'b000, 1'b0, 1'b0, 32'h102);
    cyc(); br_valid_i = 1'b0; bc++; tc++;
    chk("t4_mis", 32'(misalign_o), 32'd1);
    chk_idle("t4_mis");
    chk_counts("t4_mis");
    req(OP_BR, 3'b010, 1'b1, 1'b1, 32'h100);
    cyc(); br_valid_i = 1'b0; bc++;
    chk("t4_mis_end", 32'(misalign_o), 32'd0);
    chk("t4_ill", 32'(illegal_o), 32'd1);
    chk_idle("t4_ill");
    chk_counts("t4_ill");
    req(OP_ALU, 3'b000, 1'b1, 1'b1, 32'h100);
    cyc(); br_valid_i = 1'b0;
    chk("t4_ill_end", 32'(illegal_o), 32'd0);
    chk_idle("t4_alu");
    chk_counts("t4_alu");

    // 5: clear, wrap at 2^4, clear beats simultaneous accept
    clear_cnt_i = 1'b1;
    cyc(); clear_cnt_i = 1'b0; bc = 0; tc = 0;
    chk_counts("t5_clr");
    for (int i = 0; i < 16; i++) begin
      req(OP_JAL, 3'b000, 1'b0, 1'b0, 32'h200);
      cyc(); br_valid_i = 1'b0; bc++; tc++;
      if (i == 14) begin
        chk("t5_pre_bc", 32'(branch_count_o), 32'd15);
        chk("t5_pre_tc", 32'(taken_count_o), 32'd15);
      end
      cyc(); cyc(); cyc();
    end
    chk("t5_wrap_bc", 32'(branch_count_o), 32'd0);
    chk("t5_wrap_tc", 32'(taken_count_o), 32'd0);
    req(OP_JAL, 3'b000, 1'b0, 1'b0, 32'h200);
    clear_cnt_i = 1'b1;
    cyc(); br_valid_i = 1'b0; clear_cnt_i = 1'b0; bc = 0; tc = 0;
    chk_counts("t5_clracc");
    chk("t5_clracc_rv", 32'(redirect_valid_o), 32'd1);
    cyc(); cyc(); cyc();
    chk_idle("t5_end");

    // 6: asynchronous reset during FLUSH, then normal operation
    req(OP_BR, 3'b100, 1'b0, 1'b1, 32'h300);
    cyc(); br_valid_i = 1'b0; bc++; tc++;
    cyc();
    chk("t6_fl", 32'(flush_o), 32'd1);
    chk_counts("t6_pre");
    #2 rst_n = 1'b0;
    #1 bc = 0; tc = 0;
    chk_idle("t6_rst");
    chk("t6_pc", redirect_pc_o, 32'h0);
    chk_counts("t6_rst");
    #1 rst_n = 1'b1;
    cyc();
    req(OP_BR, 3'b101, 1'b0, 1'b0, 32'h400);
    cyc(); br_valid_i = 1'b0; bc++; tc++;
    chk("t6_rv", 32'(redirect_valid_o), 32'd1);
    chk("t6_pc2", redirect_pc_o, 32'h400);
    chk_counts("t6_post");
    cyc(); cyc(); cyc();
    chk_idle("t6_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
